// File: rtl/request_unit.sv
// request_unit
// Memory-request sequencer placed after the control unit of a single-cycle
// MIPS datapath. It turns the instruction/data access decode into memory
// request lines, stalls PC advance while a data access is outstanding,
// latches halt, detects memory timeouts and counts retired instructions
// and memory stall cycles.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   cu_iREN           instruction fetch enable from the control unit
//   cu_dREN, cu_dWEN  data read (lw) / data write (sw) decode
//   cu_halt           halt decode
//   ihit, dhit        instruction / data memory access complete
//   imemREN           instruction memory read request
//   dmemREN, dmemWEN  data memory read / write request (registered)
//   pc_en             one-cycle PC update / register-file write strobe
//   instr_hold        keep the current instruction latched
//   halt              sticky halt
//   timeout_err       sticky, halt was caused by a memory timeout
//   instr_count       saturating retired-instruction counter
//   stall_count       saturating memory-wait cycle counter
module request_unit #(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cu_iREN,
   input  logic             cu_dREN,
   input  logic             cu_dWEN,
   input  logic             cu_halt,
   input  logic             ihit,
   input  logic             dhit,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pc_en,
   output logic             instr_hold,
   output logic             halt,
   output logic             timeout_err,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DATA   = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // Value of the wait counter on the last waiting cycle before a timeout.
   localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT - 1);

   state_t           r_state;
   logic [15:0]      r_wait_cnt;
   logic             r_dmem_ren;
   logic             r_dmem_wen;
   logic             r_halt;
   logic             r_timeout_err;
   logic [CNT_W-1:0] r_instr_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_fetch_req;
   logic w_fetch_hit;
   logic w_data_hit;
   logic w_waiting;
   logic w_timeout;
   logic w_retire;

   // With cu_iREN low the fetch is idle: no request, no waiting.
   assign w_fetch_req = (r_state == ST_FETCH) & cu_iREN;
   assign w_fetch_hit = w_fetch_req & ihit;
   assign w_data_hit  = (r_state == ST_DATA) & dhit;
   assign w_waiting   = (w_fetch_req & ~ihit) | ((r_state == ST_DATA) & ~dhit);
   assign w_timeout   = w_waiting & (r_wait_cnt == LP_WAIT_LAST);
   // Retire either on a plain fetch hit or on completion of the data access;
   // RST gating keeps pc_en low while reset is asserted.
   assign w_retire    = ~RST & ((w_fetch_hit & ~cu_halt & ~cu_dREN & ~cu_dWEN) | w_data_hit);

   // Drive the outputs from state registers and the current-cycle strobe.
   always_comb begin
      imemREN     = RST | w_fetch_req;
      dmemREN     = r_dmem_ren;
      dmemWEN     = r_dmem_wen;
      pc_en       = w_retire;
      instr_hold  = (r_state == ST_DATA);
      halt        = r_halt;
      timeout_err = r_timeout_err;
      instr_count = r_instr_cnt;
      stall_count = r_stall_cnt;
   end

   // Sequencer state, wait counter, data request and halt registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state       <= ST_FETCH;
         r_wait_cnt    <= 16'd0;
         r_dmem_ren    <= 1'b0;
         r_dmem_wen    <= 1'b0;
         r_halt        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_fetch_hit) begin
                  r_wait_cnt <= 16'd0;
                  if (cu_halt) begin
                     r_state <= ST_HALTED;
                     r_halt  <= 1'b1;
                  end else if (cu_dREN | cu_dWEN) begin
                     r_state    <= ST_DATA;
                     // A simultaneous read and write resolves to the write.
                     r_dmem_ren <= cu_dREN & ~cu_dWEN;
                     r_dmem_wen <= cu_dWEN;
                  end else begin
                     r_state <= ST_FETCH;
                  end
               end else if (w_timeout) begin
                  r_state       <= ST_HALTED;
                  r_halt        <= 1'b1;
                  r_timeout_err <= 1'b1;
               end else if (w_waiting) begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end else begin
                  r_wait_cnt <= r_wait_cnt;
               end
            end
            ST_DATA: begin
               if (dhit) begin
                  r_state    <= ST_FETCH;
                  r_wait_cnt <= 16'd0;
                  r_dmem_ren <= 1'b0;
                  r_dmem_wen <= 1'b0;
               end else if (w_timeout) begin
                  r_state       <= ST_HALTED;
                  r_halt        <= 1'b1;
                  r_timeout_err <= 1'b1;
                  r_dmem_ren    <= 1'b0;
                  r_dmem_wen    <= 1'b0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            ST_HALTED: begin
               r_state <= ST_HALTED;
            end
            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

   // Saturating retired-instruction and stall-cycle counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_instr_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_retire && !(&r_instr_cnt)) begin
            r_instr_cnt <= r_instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (w_waiting && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model (pending-access / halted flags and plain counters).
module tb_request_unit;
   localparam int TO  = 8;
   localparam int CW  = 6;
   localparam int SAT = (1 << CW) - 1;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          cu_iREN = 1'b0, cu_dREN = 1'b0, cu_dWEN = 1'b0, cu_halt = 1'b0;
   logic          ihit = 1'b0, dhit = 1'b0;
   logic          imemREN, dmemREN, dmemWEN, pc_en, instr_hold, halt, timeout_err;
   logic [CW-1:0] instr_count, stall_count;

   request_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .CLK(CLK), .RST(RST),
      .cu_iREN(cu_iREN), .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
      .ihit(ihit), .dhit(dhit),
      .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .pc_en(pc_en), .instr_hold(instr_hold), .halt(halt), .timeout_err(timeout_err),
      .instr_count(instr_count), .stall_count(stall_count)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: pending data op (0 none, 1 read, 2 write), halt flags,
   // consecutive-wait count and the two saturating counters.
   bit m_halt, m_to;
   int m_pend, m_wait, m_ic, m_sc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_halt = 1'b0; m_to = 1'b0; m_pend = 0; m_wait = 0; m_ic = 0; m_sc = 0;
   endtask

   task automatic idle_inputs();
      cu_iREN = 1'b0; cu_dREN = 1'b0; cu_dWEN = 1'b0; cu_halt = 1'b0;
      ihit = 1'b0; dhit = 1'b0;
   endtask

   // Apply one cycle of inputs, compare all outputs with the model, then
   // advance the model by the rules for that cycle.
   task automatic step(input bit ir, input bit dr, input bit dw, input bit ch,
                       input bit ih, input bit dh);
      bit fetch, fh, dhv, waiting, pc;
      @(negedge CLK);
      cu_iREN = ir; cu_dREN = dr; cu_dWEN = dw; cu_halt = ch; ihit = ih; dhit = dh;
      #1;
      fetch   = !m_halt && (m_pend == 0);
      fh      = fetch && ir && ih;
      dhv     = (m_pend != 0) && dh;
      waiting = (fetch && ir && !ih) || ((m_pend != 0) && !dh);
      pc      = (fh && !ch && !dr && !dw) || dhv;
      chk("imemREN",     32'(imemREN),     32'(fetch && ir));
      chk("dmemREN",     32'(dmemREN),     32'(m_pend == 1));
      chk("dmemWEN",     32'(dmemWEN),     32'(m_pend == 2));
      chk("pc_en",       32'(pc_en),       32'(pc));
      chk("instr_hold",  32'(instr_hold),  32'(m_pend != 0));
      chk("halt",        32'(halt),        32'(m_halt));
      chk("timeout_err", 32'(timeout_err), 32'(m_to));
      chk("instr_count", 32'(instr_count), 32'(m_ic));
      chk("stall_count", 32'(stall_count), 32'(m_sc));
      if (pc && m_ic < SAT) m_ic++;
      if (waiting && m_sc < SAT) m_sc++;
      if (fh) begin
         m_wait = 0;
         if (ch) m_halt = 1'b1;
         else if (dw) m_pend = 2;
         else if (dr) m_pend = 1;
      end else if (dhv) begin
         m_pend = 0; m_wait = 0;
      end else if (waiting) begin
         if (m_wait == TO - 1) begin
            m_halt = 1'b1; m_to = 1'b1; m_pend = 0;
         end else begin
            m_wait++;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_imemREN"},  32'(imemREN), 32'd1);
      chk({tag, "_dmemREN"},  32'(dmemREN), 32'd0);
      chk({tag, "_dmemWEN"},  32'(dmemWEN), 32'd0);
      chk({tag, "_pc_en"},    32'(pc_en), 32'd0);
      chk({tag, "_hold"},     32'(instr_hold), 32'd0);
      chk({tag, "_halt"},     32'(halt), 32'd0);
      chk({tag, "_icount"},   32'(instr_count), 32'd0);
      chk({tag, "_scount"},   32'(stall_count), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      idle_inputs();
      cu_iREN = 1'b1; ihit = 1'b1;
      RST = 1'b1;
      #1;
      check_reset_outputs("rst");
      @(negedge CLK);
      idle_inputs();
      RST = 1'b0;
      model_reset();
   endtask

   // Pulse reset between clock edges and check the asynchronous response.
   task automatic reset_async();
      @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      check_reset_outputs("arst");
      @(negedge CLK);
      idle_inputs();
      RST = 1'b0;
      model_reset();
   endtask

   task automatic settle();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      model_reset();
      do_reset();

      // Ten back-to-back ALU instructions.
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 0);
      settle();
      chk("alu_icount", 32'(instr_count), 32'd10);
      chk("alu_scount", 32'(stall_count), 32'd0);

      // lw: data request for three cycles, stale ihit ignored, retire on dhit.
      do_reset();
      step(1, 1, 0, 0, 1, 0);
      chk("lw_c0_pc", 32'(pc_en), 32'd0);
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 0, 0, 1, 0);
         chk("lw_dren", 32'(dmemREN), 32'd1);
         chk("lw_hold", 32'(instr_hold), 32'd1);
         chk("lw_nopc", 32'(pc_en), 32'd0);
      end
      step(1, 0, 0, 0, 0, 1);
      chk("lw_c3_pc", 32'(pc_en), 32'd1);
      chk("lw_c3_dren", 32'(dmemREN), 32'd1);
      settle();
      chk("lw_scount", 32'(stall_count), 32'd2);
      chk("lw_icount", 32'(instr_count), 32'd1);
      chk("lw_dren_clr", 32'(dmemREN), 32'd0);

      // sw with both data requests: write wins.
      do_reset();
      step(1, 1, 1, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("sw_wen", 32'(dmemWEN), 32'd1);
      chk("sw_ren", 32'(dmemREN), 32'd0);
      step(1, 0, 0, 0, 0, 1);
      chk("sw_pc", 32'(pc_en), 32'd1);
      chk("sw_wen2", 32'(dmemWEN), 32'd1);

      // halt decode: sticky, frozen counters, no timeout flag.
      do_reset();
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 1, 1, 0);
      chk("halt_pc", 32'(pc_en), 32'd0);
      for (int i = 0; i < 50; i++)
         step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("halt_sticky", 32'(halt), 32'd1);
      chk("halt_to", 32'(timeout_err), 32'd0);
      chk("halt_imem", 32'(imemREN), 32'd0);
      chk("halt_icount", 32'(instr_count), 32'd1);

      // Timeout after exactly TO waiting cycles.
      do_reset();
      for (int i = 0; i < TO; i++) step(1, 0, 0, 0, 0, 0);
      settle();
      chk("to_halt", 32'(halt), 32'd1);
      chk("to_err", 32'(timeout_err), 32'd1);
      chk("to_scount", 32'(stall_count), 32'd8);

      // Hit on the last possible cycle beats the timeout.
      do_reset();
      for (int i = 0; i < TO - 1; i++) step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      chk("late_pc", 32'(pc_en), 32'd1);
      settle();
      chk("late_halt", 32'(halt), 32'd0);
      chk("late_scount", 32'(stall_count), 32'd7);

      // Asynchronous reset in the middle of a data read.
      do_reset();
      step(1, 1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("mid_dren", 32'(dmemREN), 32'd1);
      reset_async();
      step(1, 0, 0, 0, 1, 0);
      chk("post_rst_pc", 32'(pc_en), 32'd1);
      settle();
      chk("post_rst_icount", 32'(instr_count), 32'd1);

      // Randomized segments with varying hit rates.
      for (int seg = 0; seg < 12; seg++) begin
         int pct, halted_cycles;
         pct = (seg % 4 == 0) ? 25 : ((seg % 4 == 1) ? 60 : ((seg % 4 == 2) ? 85 : 95));
         halted_cycles = 0;
         do_reset();
         for (int c = 0; c < 300; c++) begin
            step(($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 (seg >= 8) && ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < pct),
                 ($urandom_range(0, 99) < pct));
            if (m_halt) halted_cycles++;
            if (halted_cycles > 4) begin
               do_reset();
               halted_cycles = 0;
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Memory-request sequencer that sits directly downstream of the control unit in the single-cycle MIPS datapath.
- Consumes the control unit's iREN/dREN/dWEN/halt decode and drives the instruction and data memory request lines.
- Gates PC advance and holds the current instruction while a data access is outstanding.
- Latches halt, detects memory timeouts, and keeps retired-instruction and stall-cycle counters.

Parameters:
TIMEOUT, 256, cycles without ihit/dhit in a waiting state before a timeout halt; legal range 2..65535
CNT_W, 32, width of the instr_count and stall_count counters

Ports:
CLK  in  1  system clock; all state updates on the rising edge
RST  in  1  reset; one clock; reset is asynchronous and active-high
cu_iREN  in  1  control unit instruction-read enable; FETCH is entered only while this is 1
cu_dREN  in  1  control unit data-read request; lw
cu_dWEN  in  1  control unit data-write request; sw
cu_halt  in  1  control unit halt decode
ihit  in  1  instruction memory access complete
dhit  in  1  data memory access complete
imemREN  out  1  instruction memory read request
dmemREN  out  1  data memory read request
dmemWEN  out  1  data memory write request
pc_en  out  1  one-cycle PC update strobe; also the register-file write qualifier
instr_hold  out  1  datapath must keep the current instruction latched
halt  out  1  sticky halt to the datapath and testbench
timeout_err  out  1  sticky; set when the halt was caused by a timeout
instr_count  out  CNT_W  retired-instruction count
stall_count  out  CNT_W  cycles spent waiting on memory

Behaviour:
- States: FETCH, DATA, HALTED. Reset (async) forces FETCH and clears wait_cnt, both counters, halt, timeout_err and the dmemREN/dmemWEN registers.
- Output values while RST is high: imemREN=1, all other outputs 0.
- FETCH:
  - imemREN=1 and cu_iREN=1. If cu_iREN=0, imemREN=0 and wait_cnt does not advance.
  - On ihit with cu_halt=1: next state HALTED and halt set on that edge. No pc_en; instr_count is unchanged.
  - On ihit with cu_dREN or cu_dWEN: next state DATA. dmemREN/dmemWEN are registered from cu_dREN/cu_dWEN on that edge, so the data request appears 1 cycle after ihit.
  - If both cu_dREN and cu_dWEN are 1, the write wins: dmemWEN=1, dmemREN=0.
  - On ihit with no data access and no halt: pc_en=1 combinationally in the same cycle; instr_count increments. Stay in FETCH.
- DATA:
  - imemREN=0, instr_hold=1, dmemREN/dmemWEN held stable until dhit.
  - On dhit: pc_en=1 in the same cycle, instr_count increments, and dmemREN/dmemWEN clear on the edge. Next state FETCH.
  - A stale ihit in DATA is ignored.
- HALTED:
  - Absorbing state. All request lines are 0, pc_en=0, halt=1, and the counters are frozen.
  - Exited only by reset.
- Waiting and timeout:
  - wait_cnt clears on entry to FETCH/DATA and on every hit. It increments on each waiting cycle (FETCH without ihit, or DATA without dhit).
  - When wait_cnt == TIMEOUT-1 and no hit is present that cycle: next state HALTED with timeout_err=1 and halt=1.
  - A hit arriving in that same cycle takes precedence over the timeout.
- stall_count increments every waiting cycle. It saturates at all-ones and never wraps; instr_count also saturates.
- Reset mid-DATA: dmemREN/dmemWEN drop immediately (asynchronously). No pc_en is produced for the aborted instruction.
- pc_en is never asserted in two consecutive cycles across a FETCH→DATA→FETCH sequence for the same instruction.

Test Plan:
- Reset, then ihit=1 every cycle with a plain ALU op for 10 cycles → pc_en=1 each cycle, instr_count=10, stall_count=0, dmemREN=dmemWEN=0.
- lw: ihit with cu_dREN=1 at cycle 0, dhit at cycle 3 →
  - dmemREN=1 for cycles 1–3, instr_hold=1 for cycles 1–3.
  - pc_en only at cycle 3, stall_count=2, instr_count=1.
- sw with cu_dREN=cu_dWEN=1 simultaneously → dmemWEN=1 and dmemREN=0 throughout DATA; pc_en on dhit.
- ihit with cu_halt=1 →
  - halt=1 next cycle and stays 1 for 50 further cycles despite ihit/dhit toggling.
  - Counters frozen, imemREN=0, timeout_err=0.
- TIMEOUT=8, ihit held 0 in FETCH → halt=1 and timeout_err=1 after exactly 8 waiting cycles, stall_count=8.
- Second case with TIMEOUT=8: ihit arrives on the 8th waiting cycle → no timeout, pc_en=1.
- RST pulsed mid-DATA with dmemREN=1 →
  - dmemREN=0 without waiting for a clock edge; state FETCH, counters 0.
  - The next ihit retires normally.
